// File: rtl/arp_ctrl_pkg.sv
// Shared types and constants for the ARP sequencer and its retry timer.
package arp_ctrl_pkg;

  localparam int unsigned MAC_W = 48;
  localparam int unsigned IP_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    WAIT_REPLY
  } arp_state_e;

  localparam logic ARP_TYPE_REQ = 1'b0;
  localparam logic ARP_TYPE_REP = 1'b1;

  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hff_ff_ff_ff_ff_ff;

  // MAC/IP pair as carried in the reply buffer, TX fields and peer cache
  typedef struct packed {
    logic [MAC_W-1:0] mac;
    logic [IP_W-1:0]  ip;
  } arp_peer_t;

endpackage

// File: rtl/arp_retry_timer.sv
// Re-request interval counter; counts while run and not frozen, pulses on the last cycle.
module arp_retry_timer #(
  parameter int unsigned RETRY_CYCLES = 125_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  input  logic freeze_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RETRY_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_c;

  assign step_c   = run_i && !freeze_i;
  assign expire_c = step_c && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_c) begin
      cnt_d = '0;
    end else if (step_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/arp_ctrl.sv
// ARP sequencer: resolves TARGET_IP with bounded retries, answers requests,
// caches the peer, and arbitrates the shared TX path with UDP.
module arp_ctrl
  import arp_ctrl_pkg::*;
#(
  parameter logic [IP_W-1:0] TARGET_IP    = {8'd169, 8'd254, 8'd51, 8'd120},
  parameter int unsigned     RETRY_CYCLES = 125_000_000,
  parameter int unsigned     MAX_RETRY    = 8,
  parameter bit              AUTO_START   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arp_rx_done,
  input  logic             arp_rx_type,
  input  logic [MAC_W-1:0] src_mac,
  input  logic [IP_W-1:0]  src_ip,
  input  logic             tx_done,
  output logic             arp_tx_en,
  output logic             arp_tx_type,
  output logic [MAC_W-1:0] des_mac,
  output logic [IP_W-1:0]  des_ip,
  input  logic             arp_req,
  input  logic             udp_busy,
  output logic             arp_busy,
  output logic [MAC_W-1:0] peer_mac,
  output logic [IP_W-1:0]  peer_ip,
  output logic             peer_valid,
  output logic             arp_fail
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  arp_state_e         state_q, state_d;
  logic               req_pend_q, req_pend_d;
  logic               rep_pend_q, rep_pend_d;
  arp_peer_t          rep_buf_q, rep_buf_d;
  logic               srv_rep_q, srv_rep_d;
  logic               resume_q, resume_d;
  logic               boot_q, boot_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               tx_en_q, tx_en_d;
  logic               tx_type_q, tx_type_d;
  arp_peer_t          des_q, des_d;
  logic               busy_q, busy_d;
  arp_peer_t          peer_q, peer_d;
  logic               peer_valid_q, peer_valid_d;
  logic               fail_q, fail_d;

  logic rx_req_c, hit_c, cache_rep_c;
  logic tmr_clear_c, tmr_run_c, tmr_freeze_c, tmr_expire_c;

  assign rx_req_c    = arp_rx_done && (arp_rx_type == ARP_TYPE_REQ);
  assign hit_c       = arp_rx_done && (src_ip == TARGET_IP);
  assign cache_rep_c = hit_c && (arp_rx_type == ARP_TYPE_REP);

  // A reply pending in WAIT_REPLY pre-empts the timer for the whole reply frame
  assign tmr_run_c    = (state_q == WAIT_REPLY);
  assign tmr_freeze_c = rep_pend_q && !udp_busy;

  arp_retry_timer #(
    .RETRY_CYCLES (RETRY_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (tmr_clear_c),
    .run_i    (tmr_run_c),
    .freeze_i (tmr_freeze_c),
    .expire_c (tmr_expire_c)
  );

  always_comb begin
    state_d      = state_q;
    req_pend_d   = req_pend_q;
    rep_pend_d   = rep_pend_q;
    rep_buf_d    = rep_buf_q;
    srv_rep_d    = srv_rep_q;
    resume_d     = resume_q;
    boot_d       = 1'b0;
    retry_d      = retry_q;
    tx_type_d    = tx_type_q;
    des_d        = des_q;
    peer_d       = peer_q;
    peer_valid_d = peer_valid_q;
    fail_d       = fail_q;
    tmr_clear_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if ((rep_pend_q || req_pend_q) && !udp_busy) begin
          state_d = SEND;
          if (rep_pend_q) begin
            srv_rep_d = 1'b1;
            tx_type_d = ARP_TYPE_REP;
            des_d     = rep_buf_q;
          end else begin
            srv_rep_d = 1'b0;
            tx_type_d = ARP_TYPE_REQ;
            des_d     = '{mac: BCAST_MAC, ip: TARGET_IP};
          end
        end
      end
      SEND: begin
        state_d = WAIT_DONE;
        if (srv_rep_q) rep_pend_d = 1'b0;
        else           req_pend_d = 1'b0;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (srv_rep_q) begin
            state_d  = resume_q ? WAIT_REPLY : IDLE;
            resume_d = 1'b0;
          end else begin
            state_d     = WAIT_REPLY;
            tmr_clear_c = 1'b1;
            if (retry_q != RETRY_MAX) retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
      WAIT_REPLY: begin
        if (rep_pend_q && !udp_busy) begin
          state_d   = SEND;
          resume_d  = 1'b1;
          srv_rep_d = 1'b1;
          tx_type_d = ARP_TYPE_REP;
          des_d     = rep_buf_q;
        end else if (cache_rep_c) begin
          state_d = IDLE;
        end else if (tmr_expire_c) begin
          state_d = IDLE;
          if (retry_q < RETRY_MAX) req_pend_d = 1'b1;
          else                     fail_d     = 1'b1;
        end else if (req_pend_q) begin
          state_d     = IDLE;
          tmr_clear_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Input events are applied last so a fresh event beats a same-cycle clear
    if (boot_q) req_pend_d = 1'b1;
    if (rx_req_c) begin
      rep_pend_d = 1'b1;
      rep_buf_d  = '{mac: src_mac, ip: src_ip};
    end
    if (hit_c) begin
      peer_d       = '{mac: src_mac, ip: src_ip};
      peer_valid_d = 1'b1;
    end
    if (cache_rep_c) begin
      req_pend_d  = 1'b0;
      retry_d     = '0;
      resume_d    = 1'b0;
      tmr_clear_c = 1'b1;
    end
    if (arp_req) begin
      fail_d  = 1'b0;
      retry_d = '0;
      if ((state_q == WAIT_REPLY) && (state_d == WAIT_REPLY)) tmr_clear_c = 1'b1;
      else                                                    req_pend_d  = 1'b1;
    end

    tx_en_d = (state_d == SEND);
    busy_d  = (state_d == SEND) || (state_d == WAIT_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_pend_q   <= 1'b0;
      rep_pend_q   <= 1'b0;
      rep_buf_q    <= '0;
      srv_rep_q    <= 1'b0;
      resume_q     <= 1'b0;
      boot_q       <= AUTO_START;
      retry_q      <= '0;
      tx_en_q      <= 1'b0;
      tx_type_q    <= 1'b0;
      des_q        <= '0;
      busy_q       <= 1'b0;
      peer_q       <= '0;
      peer_valid_q <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_pend_q   <= req_pend_d;
      rep_pend_q   <= rep_pend_d;
      rep_buf_q    <= rep_buf_d;
      srv_rep_q    <= srv_rep_d;
      resume_q     <= resume_d;
      boot_q       <= boot_d;
      retry_q      <= retry_d;
      tx_en_q      <= tx_en_d;
      tx_type_q    <= tx_type_d;
      des_q        <= des_d;
      busy_q       <= busy_d;
      peer_q       <= peer_d;
      peer_valid_q <= peer_valid_d;
      fail_q       <= fail_d;
    end
  end

  assign arp_tx_en   = tx_en_q;
  assign arp_tx_type = tx_type_q;
  assign des_mac     = des_q.mac;
  assign des_ip      = des_q.ip;
  assign arp_busy    = busy_q;
  assign peer_mac    = peer_q.mac;
  assign peer_ip     = peer_q.ip;
  assign peer_valid  = peer_valid_q;
  assign arp_fail    = fail_q;

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl with a short retry interval and three retries.
module tb_arp_ctrl;

  localparam int unsigned RC = 100;
  localparam logic [31:0]  TIP = 32'hA9FE3378;
  localparam logic [47:0]  PMAC = 48'h84A938BFC9A0;
  localparam logic [31:0]  QIP = 32'hC0A80114;
  localparam logic [47:0]  QMAC = 48'h020000000014;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arp_rx_done, arp_rx_type, tx_done, arp_req, udp_busy;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic        arp_tx_en, arp_tx_type, arp_busy, peer_valid, arp_fail;
  logic [47:0] des_mac, peer_mac;
  logic [31:0] des_ip, peer_ip;

  int tests = 0;
  int fails = 0;
  int n;
  int cnt;

  always #5 clk = ~clk;

  arp_ctrl #(
    .TARGET_IP    (TIP),
    .RETRY_CYCLES (RC),
    .MAX_RETRY    (3),
    .AUTO_START   (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .src_mac     (src_mac),
    .src_ip      (src_ip),
    .tx_done     (tx_done),
    .arp_tx_en   (arp_tx_en),
    .arp_tx_type (arp_tx_type),
    .des_mac     (des_mac),
    .des_ip      (des_ip),
    .arp_req     (arp_req),
    .udp_busy    (udp_busy),
    .arp_busy    (arp_busy),
    .peer_mac    (peer_mac),
    .peer_ip     (peer_ip),
    .peer_valid  (peer_valid),
    .arp_fail    (arp_fail)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse tx_done and count negedges until the next arp_tx_en (bounded)
  task automatic done_and_wait(input int max, output int cycles);
    tx_done = 1'b1;
    cycles  = 0;
    do begin
      @(negedge clk);
      tx_done = 1'b0;
      cycles++;
    end while (!arp_tx_en && cycles < max);
  endtask

  task automatic count_tx(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (arp_tx_en) pulses++;
    end
  endtask

  task automatic rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
    arp_rx_done = 1'b1;
    arp_rx_type = typ;
    src_mac     = mac;
    src_ip      = ip;
    @(negedge clk);
    arp_rx_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; arp_rx_done = 1'b0; arp_rx_type = 1'b0; tx_done = 1'b0;
    arp_req = 1'b0; udp_busy = 1'b0; src_mac = '0; src_ip = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", arp_tx_en, 0);
    chk("rst_busy", arp_busy, 0);
    chk("rst_des_mac", des_mac, 0);
    chk("rst_des_ip", des_ip, 0);
    chk("rst_peer_valid", peer_valid, 0);
    chk("rst_peer_mac", peer_mac, 0);
    chk("rst_fail", arp_fail, 0);

    // auto-start: req_pend set on first cycle after release, SEND the next
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_tx_en_early", arp_tx_en, 0);
    @(negedge clk);
    chk("boot_tx_en", arp_tx_en, 1);
    chk("boot_type", arp_tx_type, 0);
    chk("boot_des_mac", des_mac, 48'hffffffffffff);
    chk("boot_des_ip", des_ip, TIP);
    chk("boot_busy", arp_busy, 1);
    @(negedge clk);
    chk("tx_en_pulse", arp_tx_en, 0);
    chk("busy_wait_done", arp_busy, 1);

    // unanswered: RC cycles in WAIT_REPLY, then IDLE, then SEND
    done_and_wait(300, n);
    chk("retry1_gap", n, RC + 2);
    chk("retry1_type", arp_tx_type, 0);
    @(negedge clk);
    done_and_wait(300, n);
    chk("retry2_gap", n, RC + 2);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("busy_after_done", arp_busy, 0);
    count_tx(150, cnt);
    chk("no_fourth_req", cnt, 0);
    chk("fail_set", arp_fail, 1);

    // arp_req clears fail and restarts
    arp_req = 1'b1;
    @(negedge clk);
    arp_req = 1'b0;
    chk("fail_cleared", arp_fail, 0);
    @(negedge clk);
    chk("req_after_fail", arp_tx_en, 1);
    chk("req_after_fail_type", arp_tx_type, 0);

    // incoming request during WAIT_DONE of a request
    @(negedge clk);
    rx(1'b0, QMAC, QIP);
    chk("busy_during_rx", arp_busy, 1);
    done_and_wait(300, n);
    chk("reply_gap", n, 2);
    chk("reply_type", arp_tx_type, 1);
    chk("reply_des_ip", des_ip, QIP);
    chk("reply_des_mac", des_mac, QMAC);
    chk("reply_peer_valid", peer_valid, 0);

    // timer frozen during reply, then full interval resumes
    @(negedge clk);
    done_and_wait(300, n);
    chk("resume_gap", n, RC + 2);
    chk("resume_type", arp_tx_type, 0);
    chk("resume_des_ip", des_ip, TIP);

    // reply lands on the expiry edge
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    repeat (RC - 1) @(negedge clk);
    rx(1'b1, PMAC, TIP);
    chk("cache_valid", peer_valid, 1);
    chk("cache_mac", peer_mac, PMAC);
    chk("cache_ip", peer_ip, TIP);
    count_tx(200, cnt);
    chk("no_retry_after_reply", cnt, 0);
    chk("fail_after_reply", arp_fail, 0);

    // mismatched reply and stray tx_done change nothing
    rx(1'b1, 48'h111111111111, 32'h0A000001);
    chk("mismatch_ip", peer_ip, TIP);
    chk("mismatch_mac", peer_mac, PMAC);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    count_tx(5, cnt);
    chk("stray_no_tx", cnt, 0);
    chk("stray_busy", arp_busy, 0);

    // udp hold-off for 50 cycles
    arp_req  = 1'b1;
    udp_busy = 1'b1;
    @(negedge clk);
    arp_req = 1'b0;
    count_tx(49, cnt);
    chk("udp_holdoff", cnt, 0);
    udp_busy = 1'b0;
    @(negedge clk);
    chk("udp_release_tx", arp_tx_en, 1);
    chk("udp_release_busy", arp_busy, 1);
    chk("rereq_peer_valid", peer_valid, 1);
    udp_busy = 1'b1;
    @(negedge clk);
    chk("busy_ignores_udp", arp_busy, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("busy_drop", arp_busy, 0);
    rx(1'b1, PMAC, TIP);
    udp_busy = 1'b0;
    count_tx(150, cnt);
    chk("resolved_no_tx", cnt, 0);
    chk("final_peer_valid", peer_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
